// File: rtl/i_cache_pkg.sv
// Shared types for the N-way instruction cache: FSM state encoding, field-width
// helpers and the line record shape used by the default geometry.
package i_cache_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_MEM_REQ,
    S_REFILL,
    S_WR_WAIT,
    S_RESP
  } state_t;

  localparam int DEF_ADD_WIDTH  = 12;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_WAYS       = 2;
  localparam int DEF_SETS       = 16;
  localparam int DEF_WPL        = 4;

  function automatic int off_width(input int wpl);
    return $clog2(wpl);
  endfunction

  function automatic int idx_width(input int sets);
    return $clog2(sets);
  endfunction

  // Address is split {tag, index, offset}; the tag takes whatever is left over.
  function automatic int tag_width(input int add_w, input int sets, input int wpl);
    return add_w - $clog2(sets) - $clog2(wpl);
  endfunction

  localparam int DEF_OFF_W = off_width(DEF_WPL);
  localparam int DEF_IDX_W = idx_width(DEF_SETS);
  localparam int DEF_TAG_W = tag_width(DEF_ADD_WIDTH, DEF_SETS, DEF_WPL);

  typedef struct packed {
    logic                              valid;
    logic [DEF_TAG_W-1:0]              tag;
    logic [DEF_WPL*DEF_DATA_WIDTH-1:0] data;
  } line_t;

endpackage

// File: rtl/i_cache_lru.sv
// True-LRU age update and victim selection for one set (purely combinational).
module i_cache_lru
  import i_cache_pkg::*;
#(
  parameter int WAYS  = 2,
  parameter int AGE_W = $clog2(WAYS)
) (
  input  logic [WAYS*AGE_W-1:0] i_age,
  input  logic [WAYS-1:0]       i_valid,
  input  logic [AGE_W-1:0]      i_touch_way,
  output logic [WAYS*AGE_W-1:0] o_age,
  output logic [AGE_W-1:0]      o_victim
);

  logic [AGE_W-1:0] w_old_age;

  always_comb begin
    w_old_age = i_age[i_touch_way*AGE_W +: AGE_W];
    o_age     = i_age;
    for (int w = 0; w < WAYS; w++) begin
      if (AGE_W'(w) == i_touch_way) begin
        o_age[w*AGE_W +: AGE_W] = '0;
      end else if (i_age[w*AGE_W +: AGE_W] < w_old_age) begin
        o_age[w*AGE_W +: AGE_W] = i_age[w*AGE_W +: AGE_W] + AGE_W'(1);
      end
    end
  end

  // Descending scans so the lowest-index invalid way wins over the oldest way.
  always_comb begin
    o_victim = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (i_age[w*AGE_W +: AGE_W] == AGE_W'(WAYS - 1)) o_victim = AGE_W'(w);
    end
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!i_valid[w]) o_victim = AGE_W'(w);
    end
  end

endmodule

// File: rtl/i_cache_nway.sv
// N-way set-associative instruction cache: read-allocate burst refill, write-through
// no-allocate writes. Define I_CACHE_PERF_CNT_EN to add hit/miss performance counters.
module i_cache_nway
  import i_cache_pkg::*;
#(
  parameter int ADD_WIDTH      = DEF_ADD_WIDTH,
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int WAYS           = DEF_WAYS,
  parameter int SETS           = DEF_SETS,
  parameter int WORDS_PER_LINE = DEF_WPL
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // Both sides: a transfer happens on a rising edge where valid and ready are both high;
  // the initiator holds valid and its payload stable until that edge.
  input  logic                  i_cpu_req_valid,
  output logic                  o_cpu_req_ready,
  input  logic [ADD_WIDTH-1:0]  i_cpu_addr,
  input  logic                  i_cpu_wren,
  input  logic [DATA_WIDTH-1:0] i_cpu_din,
  output logic                  o_cpu_resp_valid,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  output logic                  o_cpu_hit,
  output logic                  o_mem_req_valid,
  input  logic                  i_mem_req_ready,
  output logic                  o_mem_req_we,
  output logic [ADD_WIDTH-1:0]  o_mem_req_addr,
  output logic [DATA_WIDTH-1:0] o_mem_req_wdata,
  input  logic                  i_mem_resp_valid,
  input  logic [DATA_WIDTH-1:0] i_mem_resp_data,
  output state_t                o_dbg_state
`ifdef I_CACHE_PERF_CNT_EN
  ,
  output logic [31:0]           o_perf_hit_cnt,
  output logic [31:0]           o_perf_miss_cnt
`endif
);

  localparam int OFF_W = off_width(WORDS_PER_LINE);
  localparam int IDX_W = idx_width(SETS);
  localparam int TAG_W = tag_width(ADD_WIDTH, SETS, WORDS_PER_LINE);
  localparam int AGE_W = $clog2(WAYS);

  state_t                r_state;
  logic                  r_cpu_req_ready;
  logic                  r_resp_valid;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_hit;
  logic                  r_mem_req_valid;
  logic                  r_mem_req_we;
  logic [ADD_WIDTH-1:0]  r_mem_req_addr;
  logic [DATA_WIDTH-1:0] r_mem_req_wdata;
  logic [ADD_WIDTH-1:0]  r_addr;
  logic                  r_wren;
  logic [DATA_WIDTH-1:0] r_din;
  logic [AGE_W-1:0]      r_victim;
  logic [OFF_W-1:0]      r_beat;
  logic [DATA_WIDTH-1:0] r_fill_word;

  logic [DATA_WIDTH-1:0] r_data  [SETS][WAYS][WORDS_PER_LINE];
  logic [TAG_W-1:0]      r_tag   [SETS][WAYS];
  logic [WAYS-1:0]       r_valid [SETS];
  logic [WAYS*AGE_W-1:0] r_age   [SETS];

  logic [TAG_W-1:0]      w_tag;
  logic [IDX_W-1:0]      w_idx;
  logic [OFF_W-1:0]      w_off;
  logic                  w_hit;
  logic [AGE_W-1:0]      w_hit_way;
  logic [AGE_W-1:0]      w_touch_way;
  logic [AGE_W-1:0]      w_victim;
  logic [WAYS*AGE_W-1:0] w_age_next;
  logic                  w_fill_we;
  logic                  w_wr_hit;
  logic                  w_last_beat;

  assign w_tag = r_addr[ADD_WIDTH-1 -: TAG_W];
  assign w_idx = r_addr[OFF_W +: IDX_W];
  assign w_off = r_addr[OFF_W-1:0];

  always_comb begin
    w_hit     = 1'b0;
    w_hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (r_valid[w_idx][w] && (r_tag[w_idx][w] == w_tag)) begin
        w_hit     = 1'b1;
        w_hit_way = AGE_W'(w);
      end
    end
  end

  // Lookup touches the hit way; a completed refill touches the victim way.
  assign w_touch_way = (r_state == S_LOOKUP) ? w_hit_way : r_victim;
  assign w_fill_we   = (r_state == S_REFILL) && i_mem_resp_valid;
  assign w_wr_hit    = (r_state == S_LOOKUP) && r_wren && w_hit;
  assign w_last_beat = (r_beat == OFF_W'(WORDS_PER_LINE - 1));

  i_cache_lru #(.WAYS(WAYS), .AGE_W(AGE_W)) u_lru (
    .i_age       (r_age[w_idx]),
    .i_valid     (r_valid[w_idx]),
    .i_touch_way (w_touch_way),
    .o_age       (w_age_next),
    .o_victim    (w_victim)
  );

  always_ff @(posedge clk) begin
    if (w_fill_we) begin
      r_data[w_idx][r_victim][r_beat] <= i_mem_resp_data;
      r_tag[w_idx][r_victim]          <= w_tag;
    end
    if (w_wr_hit) r_data[w_idx][w_hit_way][w_off] <= r_din;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state         <= S_IDLE;
      r_cpu_req_ready <= 1'b1;
      r_resp_valid    <= 1'b0;
      r_rdata         <= '0;
      r_hit           <= 1'b0;
      r_mem_req_valid <= 1'b0;
      r_mem_req_we    <= 1'b0;
      r_mem_req_addr  <= '0;
      r_mem_req_wdata <= '0;
      r_addr          <= '0;
      r_wren          <= 1'b0;
      r_din           <= '0;
      r_victim        <= '0;
      r_beat          <= '0;
      r_fill_word     <= '0;
      for (int s = 0; s < SETS; s++) begin
        r_valid[s] <= '0;
        for (int w = 0; w < WAYS; w++) r_age[s][w*AGE_W +: AGE_W] <= AGE_W'(w);
      end
    end else begin
      r_resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (i_cpu_req_valid && r_cpu_req_ready) begin
            r_addr          <= i_cpu_addr;
            r_wren          <= i_cpu_wren;
            r_din           <= i_cpu_din;
            r_cpu_req_ready <= 1'b0;
            r_state         <= S_LOOKUP;
          end
        end
        S_LOOKUP: begin
          r_hit <= w_hit;
          if (w_hit) r_age[w_idx] <= w_age_next;
          if (!r_wren && w_hit) begin
            r_rdata <= r_data[w_idx][w_hit_way][w_off];
            r_state <= S_RESP;
          end else begin
            // Invalidate the victim up front so an interrupted refill can never hit.
            if (!r_wren) begin
              r_victim                  <= w_victim;
              r_valid[w_idx][w_victim]  <= 1'b0;
              r_beat                    <= '0;
            end
            r_state <= S_MEM_REQ;
          end
        end
        S_MEM_REQ: begin
          if (!r_mem_req_valid) begin
            r_mem_req_valid <= 1'b1;
            r_mem_req_we    <= r_wren;
            r_mem_req_addr  <= r_wren ? r_addr : {w_tag, w_idx, {OFF_W{1'b0}}};
            r_mem_req_wdata <= r_din;
          end else if (i_mem_req_ready) begin
            r_mem_req_valid <= 1'b0;
            r_state         <= r_mem_req_we ? S_WR_WAIT : S_REFILL;
          end
        end
        S_REFILL: begin
          if (i_mem_resp_valid) begin
            if (r_beat == w_off) r_fill_word <= i_mem_resp_data;
            r_beat <= r_beat + OFF_W'(1);
            if (w_last_beat) begin
              r_valid[w_idx][r_victim] <= 1'b1;
              r_age[w_idx]             <= w_age_next;
              r_rdata                  <= (r_beat == w_off) ? i_mem_resp_data : r_fill_word;
              r_state                  <= S_RESP;
            end
          end
        end
        S_WR_WAIT: begin
          if (i_mem_resp_valid) r_state <= S_RESP;
        end
        S_RESP: begin
          r_resp_valid    <= 1'b1;
          r_cpu_req_ready <= 1'b1;
          r_state         <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef I_CACHE_PERF_CNT_EN
  logic [31:0] r_perf_hit;
  logic [31:0] r_perf_miss;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_perf_hit  <= '0;
      r_perf_miss <= '0;
    end else if (r_state == S_RESP) begin
      if (r_hit && (r_perf_hit != '1))    r_perf_hit  <= r_perf_hit + 32'd1;
      if (!r_hit && (r_perf_miss != '1))  r_perf_miss <= r_perf_miss + 32'd1;
    end
  end

  assign o_perf_hit_cnt  = r_perf_hit;
  assign o_perf_miss_cnt = r_perf_miss;
`endif

  assign o_cpu_req_ready  = r_cpu_req_ready;
  assign o_cpu_resp_valid = r_resp_valid;
  assign o_cpu_rdata      = r_rdata;
  assign o_cpu_hit        = r_hit;
  assign o_mem_req_valid  = r_mem_req_valid;
  assign o_mem_req_we     = r_mem_req_we;
  assign o_mem_req_addr   = r_mem_req_addr;
  assign o_mem_req_wdata  = r_mem_req_wdata;
  assign o_dbg_state      = r_state;

endmodule
